full_adder_core: RTL and testbench
==================================

# full_adder_core

Registered full-adder datapath block: adds two WIDTH-bit operands plus a carry-in and presents sum and carry-out one clock after the inputs are sampled. With WIDTH=1 it is the classic single-bit full adder (s = x^y^c_in, c_out = majority). It is used as the arithmetic leaf for ripple-carry chains and as a known-good reference for adder verification.

## Interface
- WIDTH, default 1: operand/sum width in bits, legal range 1..64.
- clk  input  1  rising-edge clock, sole clock domain.
- rst_n  input  1  asynchronous active-low reset. Assertion clears all registers immediately. Deassertion is synchronous to clk.
- in_valid  input  1  x, y, c_in are sampled on this rising edge.
- x  input  WIDTH  operand A, unsigned (two's-complement view used only for overflow).
- y  input  WIDTH  operand B.
- c_in  input  1  carry-in to bit 0.
- out_valid  output  1  s/c_out hold the result of the last sampled operands.
- s  output  WIDTH  sum bits.
- c_out  output  1  carry-out of bit WIDTH-1.
- ovf  output  1  signed overflow (present only with FULL_ADDER_OVF_EN).

## Operation
- Each bit i is a full-adder cell:
  - s[i] = x[i] ^ y[i] ^ c[i]
  - c[i+1] = (x[i]&y[i]) | (x[i]&c[i]) | (y[i]&c[i])
  - c[0] = c_in; c_out = c[WIDTH].
- The carry chain is an explicit per-bit ripple of cells, not a behavioural "+".
- Result is exact: {c_out, s} = x + y + c_in, computed at WIDTH+1 bits, with no truncation of the carry.
- When in_valid=1 at a rising edge:
  - the result registers load the new result;
  - out_valid is set to 1 on that edge.
- When in_valid=0 at a rising edge:
  - s, c_out and ovf hold their previous values;
  - out_valid is cleared to 0 on that edge.
- Inputs are don't-care while in_valid=0.
- No backpressure. Every accepted input produces exactly one output cycle.

## Timing
- Latency: 1 cycle. Result and out_valid are visible after the edge that sampled in_valid=1.
- Throughput: 1 result per cycle. Back-to-back in_valid yields back-to-back out_valid.
- Outputs are driven from flops only, with no combinational input-to-output path.
- Reset values: s=0, c_out=0, ovf=0, out_valid=0.
- Reset asserted mid-operation aborts the in-flight result. The first valid output after release comes from the first in_valid sampled after release.
- The carry path is WIDTH cells long and must close timing at the target clock for the configured WIDTH.

## Configuration
- FULL_ADDER_OVF_EN defined:
  - ovf port exists and is registered with s.
  - ovf = c[WIDTH] ^ c[WIDTH-1], i.e. two's-complement overflow.
  - For WIDTH=1, ovf = c_out ^ c_in.
- FULL_ADDER_OVF_EN undefined:
  - ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=1 exhaustive truth table: apply all 8 {c_in,y,x} combinations, one per cycle. Required results one cycle later:
  - 000->s0c0
  - 010->s1c0
  - 100->s1c0
  - 110->s0c1
  - 001->s1c0
  - 011->s0c1
  - 101->s0c1
  - 111->s1c1
- WIDTH=8 carry ripple: x=0xFF, y=0x01, c_in=0 -> s=0x00, c_out=1. Also x=0xFF, y=0xFF, c_in=1 -> s=0xFF, c_out=1.
- Hold behaviour: x=1, y=1, c_in=1 valid, then in_valid=0 with random inputs -> s/c_out stay 1/1 and out_valid drops to 0.
- Async reset: assert rst_n=0 between edges with s=1, c_out=1 -> all outputs read 0 before the next clk edge. After release, the first output follows the first valid input.
- Overflow (FULL_ADDER_OVF_EN, WIDTH=8):
  - 0x7F+0x01+0 -> ovf=1, s=0x80, c_out=0.
  - 0x80+0x80+0 -> ovf=1, s=0x00, c_out=1.
  - 0x01+0x01 -> ovf=0.
- Random regression, WIDTH in {1,8,32}: 10k random valid/invalid cycles, checking {c_out,s} == x+y+c_in one cycle later against a model.

Source files
------------

// File: rtl/full_adder_core.sv
// Registered WIDTH-bit ripple-carry full adder with one-cycle latency.
// Define FULL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module full_adder_core #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             c_out
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cOut_d, cOut_q;
  logic             outValid_q;
  logic             carry;
`ifdef FULL_ADDER_OVF_EN
  logic             carryIntoMsb;
  logic             ovf_d, ovf_q;
`endif

  // Ripple of single-bit cells; carry is threaded from bit 0 to bit WIDTH-1.
  always_comb begin
    sum_d = '0;
    carry = c_in;
`ifdef FULL_ADDER_OVF_EN
    carryIntoMsb = c_in;
`endif
    for (int i = 0; i < WIDTH; i++) begin
`ifdef FULL_ADDER_OVF_EN
      carryIntoMsb = carry;
`endif
      sum_d[i] = x[i] ^ y[i] ^ carry;
      carry    = (x[i] & y[i]) | (x[i] & carry) | (y[i] & carry);
    end
    cOut_d = carry;
`ifdef FULL_ADDER_OVF_EN
    ovf_d = carry ^ carryIntoMsb;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q      <= '0;
      cOut_q     <= 1'b0;
      outValid_q <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      outValid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cOut_q <= cOut_d;
`ifdef FULL_ADDER_OVF_EN
        ovf_q  <= ovf_d;
`endif
      end
    end
  end

  assign s         = sum_q;
  assign c_out     = cOut_q;
  assign out_valid = outValid_q;
`ifdef FULL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_core.sv
// Self-checking bench for full_adder_core at WIDTH 1, 8 and 32 against an arithmetic model.
// Overflow checks are compiled in when FULL_ADDER_OVF_EN is defined.
module tb_full_adder_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic inValid;

  logic [63:0] xIn [3];
  logic [63:0] yIn [3];
  logic        cIn [3];
  int          widthOf [3];

  logic [0:0]  x1, y1, s1;
  logic [7:0]  x8, y8, s8;
  logic [31:0] x32, y32, s32;
  logic        co1, co8, co32;
  logic        ov1, ov8, ov32;
`ifdef FULL_ADDER_OVF_EN
  logic        ovf1, ovf8, ovf32;
`endif

  assign x1  = xIn[0][0:0];
  assign y1  = yIn[0][0:0];
  assign x8  = xIn[1][7:0];
  assign y8  = yIn[1][7:0];
  assign x32 = xIn[2][31:0];
  assign y32 = yIn[2][31:0];

  full_adder_core #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .x(x1), .y(y1), .c_in(cIn[0]),
    .out_valid(ov1), .s(s1), .c_out(co1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  full_adder_core #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .x(x8), .y(y8), .c_in(cIn[1]),
    .out_valid(ov8), .s(s8), .c_out(co8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  full_adder_core #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .x(x32), .y(y32), .c_in(cIn[2]),
    .out_valid(ov32), .s(s32), .c_out(co32)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf32)
`endif
  );

  logic [64:0] obsR [3];
  logic        obsV [3];
  assign obsR[0] = 65'({co1, s1});
  assign obsR[1] = 65'({co8, s8});
  assign obsR[2] = 65'({co32, s32});
  assign obsV[0] = ov1;
  assign obsV[1] = ov8;
  assign obsV[2] = ov32;
`ifdef FULL_ADDER_OVF_EN
  logic obsO [3];
  assign obsO[0] = ovf1;
  assign obsO[1] = ovf8;
  assign obsO[2] = ovf32;
`endif

  logic [64:0] expRes [3];
  logic        expOvf [3];
  logic        expValid;
  int          testsRun = 0;
  int          testsFailed = 0;

  function automatic logic [63:0] maskOf(input int w);
    logic [64:0] m;
    m = (65'd1 << w) - 65'd1;
    return m[63:0];
  endfunction

  function automatic longint signedOf(input logic [63:0] v, input int w);
    longint r;
    r = longint'(v & maskOf(w));
    if (v[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  // Overflow means the true signed sum falls outside the w-bit two's-complement range.
  function automatic logic modelOvf(input logic [63:0] a, input logic [63:0] b,
                                    input logic c, input int w);
    longint sum;
    longint hi;
    sum = signedOf(a, w) + signedOf(b, w) + longint'(c);
    hi  = (longint'(1) << (w - 1));
    return (sum > hi - 1) || (sum < -hi);
  endfunction

  task automatic checkOutput(input string tag, input logic [64:0] observed,
                             input logic [64:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("%s_w%0d_res", tag, widthOf[k]), obsR[k], expRes[k]);
      checkOutput($sformatf("%s_w%0d_valid", tag, widthOf[k]), 65'(obsV[k]), 65'(expValid));
`ifdef FULL_ADDER_OVF_EN
      checkOutput($sformatf("%s_w%0d_ovf", tag, widthOf[k]), 65'(obsO[k]), 65'(expOvf[k]));
`endif
    end
  endtask

  task automatic randomizeInputs();
    for (int k = 0; k < 3; k++) begin
      xIn[k] = {$urandom, $urandom} & maskOf(widthOf[k]);
      yIn[k] = {$urandom, $urandom} & maskOf(widthOf[k]);
      cIn[k] = 1'($urandom_range(0, 1));
    end
  endtask

  // Drive at a falling edge, update the model as the next rising edge will, then move to the next falling edge.
  task automatic applyStimulus(input logic valid);
    inValid = valid;
    if (valid) begin
      for (int k = 0; k < 3; k++) begin
        expRes[k] = 65'(xIn[k]) + 65'(yIn[k]) + 65'(cIn[k]);
        expOvf[k] = modelOvf(xIn[k], yIn[k], cIn[k], widthOf[k]);
      end
    end
    expValid = valid;
    @(negedge clk);
  endtask

  task automatic clearModel();
    for (int k = 0; k < 3; k++) begin
      expRes[k] = '0;
      expOvf[k] = 1'b0;
    end
    expValid = 1'b0;
  endtask

  logic [7:0] sumTab;
  logic [7:0] carryTab;

  initial begin
    widthOf[0] = 1;
    widthOf[1] = 8;
    widthOf[2] = 32;
    for (int k = 0; k < 3; k++) begin
      xIn[k] = '0;
      yIn[k] = '0;
      cIn[k] = 1'b0;
    end
    sumTab   = 8'b1001_0110;
    carryTab = 8'b1110_1000;
    inValid  = 1'b0;
    rst_n    = 1'b0;
    clearModel();

    repeat (2) @(negedge clk);
    checkAll("reset");
    rst_n = 1'b1;

    // Truth table indexed by {c_in,y,x} on the single-bit instance.
    for (int i = 0; i < 8; i++) begin
      randomizeInputs();
      xIn[0] = 64'(i & 1);
      yIn[0] = 64'((i >> 1) & 1);
      cIn[0] = 1'((i >> 2) & 1);
      applyStimulus(1'b1);
      checkAll($sformatf("tt%0d", i));
      checkOutput($sformatf("tt%0d_table", i), obsR[0], 65'({carryTab[i], sumTab[i]}));
    end

    randomizeInputs();
    xIn[1] = 64'hFF; yIn[1] = 64'h01; cIn[1] = 1'b0;
    applyStimulus(1'b1);
    checkAll("ripple_a");
    checkOutput("ripple_a_const", obsR[1], 65'h100);

    randomizeInputs();
    xIn[1] = 64'hFF; yIn[1] = 64'hFF; cIn[1] = 1'b1;
    applyStimulus(1'b1);
    checkAll("ripple_b");
    checkOutput("ripple_b_const", obsR[1], 65'h1FF);

    randomizeInputs();
    xIn[1] = 64'h7F; yIn[1] = 64'h01; cIn[1] = 1'b0;
    applyStimulus(1'b1);
    checkAll("ovf_a");
    checkOutput("ovf_a_const", obsR[1], 65'h080);
`ifdef FULL_ADDER_OVF_EN
    checkOutput("ovf_a_flag", 65'(ovf8), 65'd1);
`endif

    randomizeInputs();
    xIn[1] = 64'h80; yIn[1] = 64'h80; cIn[1] = 1'b0;
    applyStimulus(1'b1);
    checkAll("ovf_b");
    checkOutput("ovf_b_const", obsR[1], 65'h100);
`ifdef FULL_ADDER_OVF_EN
    checkOutput("ovf_b_flag", 65'(ovf8), 65'd1);
`endif

    randomizeInputs();
    xIn[1] = 64'h01; yIn[1] = 64'h01; cIn[1] = 1'b0;
    applyStimulus(1'b1);
    checkAll("ovf_c");
`ifdef FULL_ADDER_OVF_EN
    checkOutput("ovf_c_flag", 65'(ovf8), 65'd0);
`endif

    // Hold: result must persist through invalid cycles with changing inputs.
    randomizeInputs();
    xIn[0] = 64'd1; yIn[0] = 64'd1; cIn[0] = 1'b1;
    applyStimulus(1'b1);
    checkAll("hold_load");
    for (int n = 0; n < 3; n++) begin
      randomizeInputs();
      applyStimulus(1'b0);
      checkAll($sformatf("hold%0d", n));
      checkOutput($sformatf("hold%0d_const", n), obsR[0], 65'd3);
    end

    // Asynchronous reset between edges, held across an edge with valid inputs present.
    #2 rst_n = 1'b0;
    #1;
    clearModel();
    checkAll("async_rst");
    randomizeInputs();
    inValid = 1'b1;
    @(negedge clk);
    checkAll("rst_held");
    rst_n = 1'b1;
    randomizeInputs();
    applyStimulus(1'b0);
    checkAll("post_rst_idle");
    randomizeInputs();
    applyStimulus(1'b1);
    checkAll("post_rst_first");

    for (int n = 0; n < 10000; n++) begin
      randomizeInputs();
      applyStimulus($urandom_range(0, 3) != 0);
      checkAll("rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
